// File: rtl/correlator_pkg.sv
// Shared types and saturation helpers for the delay-and-correlate front end.
package correlator_pkg;

  localparam int CPLX_W = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] i;
    logic signed [CPLX_W-1:0] q;
  } cplx_t;

  typedef enum logic [1:0] {FLUSH, FILL, RUN} state_e;

  // Clamp a signed value into a signed field of the given width.
  function automatic logic [63:0] sat_signed(input logic signed [63:0] v, input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  function automatic logic [63:0] sat_unsigned(input logic signed [63:0] v, input int bits);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< bits) - 64'sd1;
    if (v > hi) return hi;
    else if (v < 64'sd0) return 64'd0;
    else return v;
  endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// 1R1W sample delay line: writes at a wrapping pointer, reads wptr-offset one cycle later.
// A read and write to the same address return the old contents (needed for offset == DEPTH).
module sample_ring_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [2*WIDTH-1:0]             wr_data,
  input  logic [$clog2(DEPTH+1)-1:0]     offset,
  output logic [2*WIDTH-1:0]             rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DEPTH + 1) + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      raddr;
  logic [SW-1:0]      wext;
  logic [SW-1:0]      oext;

  assign wext  = SW'(wptr);
  assign oext  = SW'(offset);
  assign raddr = (wext >= oext) ? AW'(wext - oext) : AW'(wext + SW'(DEPTH) - oext);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wr_data;
      rd_data   <= mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
    end else if (wr_en) begin
      wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
    end
  end

endmodule

// File: rtl/delay_correlator.sv
// Delay-and-correlate front end: C = sum x[n-k]*conj(x[n-k-D]), P = sum |x[n-k]|^2 over LENGTH.
// Three-stage pipeline (delay read, multiply, window accumulate) with a flush/fill/run FSM.
module delay_correlator
  import correlator_pkg::*;
#(
  parameter int WIDTH     = CPLX_W,
  parameter int MAX_DELAY = 64,
  parameter int LENGTH    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   cfg_delay,
  input  logic                             flush,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [2*WIDTH-1:0]               s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [6*WIDTH-1:0]               m_data
);

  localparam int DW = $clog2(MAX_DELAY + 1);
  localparam int PW = 2*WIDTH + 1;
  localparam int AW = PW + $clog2(LENGTH);
  localparam int CW = $clog2(MAX_DELAY + LENGTH + 1);
  localparam int OW = 2*WIDTH;

  state_e state, state_nx;
  logic [DW-1:0] dly;
  logic [CW-1:0] fill_cnt, fill_target;
  logic en, accept, kill, dly_ok, out_tag;

  logic               s1_vld, s1_out, s1_dok;
  logic [2*WIDTH-1:0] s1_x, dly_x;

  logic signed [PW-1:0] xi, xq, yi, yq, prod_i, prod_q;
  logic        [PW-1:0] energy;

  logic                 s2_vld, s2_out;
  logic signed [PW-1:0] s2_pi, s2_pq;
  logic        [PW-1:0] s2_e;

  logic signed [PW-1:0] hist_i [LENGTH];
  logic signed [PW-1:0] hist_q [LENGTH];
  logic        [PW-1:0] hist_e [LENGTH];

  logic signed [AW-1:0] acc_i, acc_q, acc_i_nx, acc_q_nx;
  logic        [AW-1:0] acc_e, acc_e_nx;

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] c);
    if (c == '0) return DW'(1);
    if (c > DW'(MAX_DELAY)) return DW'(MAX_DELAY);
    return c;
  endfunction

  assign en          = !m_valid || m_ready;
  assign s_ready     = en && (state != FLUSH) && !flush;
  assign accept      = s_valid && s_ready;
  assign kill        = flush || (state == FLUSH);
  assign fill_target = CW'(dly) + CW'(LENGTH);
  // Delayed samples from before the flush are masked to zero instead of trusting RAM contents.
  assign dly_ok      = (fill_cnt >= CW'(dly));
  assign out_tag     = (state == RUN) || (fill_cnt + CW'(1) == fill_target);

  always_comb begin
    state_nx = state;
    case (state)
      FLUSH:   state_nx = FILL;
      FILL:    if (accept && (fill_cnt + CW'(1) == fill_target)) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = FLUSH;
    endcase
    if (flush) state_nx = FLUSH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FLUSH;
      dly      <= DW'(MAX_DELAY);
      fill_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == FLUSH) begin
        dly      <= clamp_delay(cfg_delay);
        fill_cnt <= '0;
      end else if (accept && state == FILL) begin
        fill_cnt <= fill_cnt + CW'(1);
      end
    end
  end

  sample_ring_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data (s_data),
    .offset  (dly),
    .rd_data (dly_x)
  );

  always_comb begin
    xi     = PW'($signed(s1_x[2*WIDTH-1:WIDTH]));
    xq     = PW'($signed(s1_x[WIDTH-1:0]));
    yi     = s1_dok ? PW'($signed(dly_x[2*WIDTH-1:WIDTH])) : '0;
    yq     = s1_dok ? PW'($signed(dly_x[WIDTH-1:0]))       : '0;
    prod_i = xi*yi + xq*yq;
    prod_q = xq*yi - xi*yq;
    energy = xi*xi + xq*xq;
  end

  always_comb begin
    acc_i_nx = acc_i + AW'(s2_pi) - AW'(hist_i[LENGTH-1]);
    acc_q_nx = acc_q + AW'(s2_pq) - AW'(hist_q[LENGTH-1]);
    acc_e_nx = acc_e + AW'(s2_e)  - AW'(hist_e[LENGTH-1]);
  end

  always_ff @(posedge clk) begin
    if (state == FLUSH) begin
      for (int k = 0; k < LENGTH; k++) begin
        hist_i[k] <= '0;
        hist_q[k] <= '0;
        hist_e[k] <= '0;
      end
    end else if (en && s2_vld) begin
      hist_i[0] <= s2_pi;
      hist_q[0] <= s2_pq;
      hist_e[0] <= s2_e;
      for (int k = 1; k < LENGTH; k++) begin
        hist_i[k] <= hist_i[k-1];
        hist_q[k] <= hist_q[k-1];
        hist_e[k] <= hist_e[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld  <= 1'b0;
      s1_out  <= 1'b0;
      s1_dok  <= 1'b0;
      s1_x    <= '0;
      s2_vld  <= 1'b0;
      s2_out  <= 1'b0;
      s2_pi   <= '0;
      s2_pq   <= '0;
      s2_e    <= '0;
      acc_i   <= '0;
      acc_q   <= '0;
      acc_e   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (kill) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      m_valid <= 1'b0;
      acc_i   <= '0;
      acc_q   <= '0;
      acc_e   <= '0;
    end else if (en) begin
      s1_vld  <= accept;
      s1_out  <= out_tag;
      s1_dok  <= dly_ok;
      s1_x    <= s_data;
      s2_vld  <= s1_vld;
      s2_out  <= s1_out;
      s2_pi   <= prod_i;
      s2_pq   <= prod_q;
      s2_e    <= energy;
      if (s2_vld) begin
        acc_i <= acc_i_nx;
        acc_q <= acc_q_nx;
        acc_e <= acc_e_nx;
      end
      m_valid <= s2_vld && s2_out;
      if (s2_vld && s2_out) begin
        m_data <= {OW'(sat_signed(64'(acc_i_nx), OW)),
                   OW'(sat_signed(64'(acc_q_nx), OW)),
                   OW'(sat_unsigned($signed(64'(acc_e_nx)), OW))};
      end
    end
  end

endmodule

// File: tb/tb_delay_correlator.sv
// Randomized bench for delay_correlator against a sliding-window sum model over all post-flush samples.
module tb_delay_correlator;
  import correlator_pkg::*;

  localparam int W    = 16;
  localparam int MAXD = 64;
  localparam int L    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  cfg_delay = 7'd16;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [95:0] m_data;

  int n_cmp = 0;
  int n_bad = 0;

  cplx_t       xs[$];
  logic [95:0] exp_q[$];
  int          exp_cyc[$];
  int          md = 16;
  int          cyc = 0;
  int          out_cnt = 0;
  logic [95:0] last_out = '0;
  bit          lat_on = 0;
  int          ready_pct = 100;
  int          stall_cnt = 0;
  bit          stall_prev = 0;
  logic [95:0] prev_data = '0;

  always #5 clk = ~clk;

  delay_correlator #(.WIDTH(W), .MAX_DELAY(MAXD), .LENGTH(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_delay (cfg_delay),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int dclamp(input int c);
    if (c == 0) return 1;
    if (c > MAXD) return MAXD;
    return c;
  endfunction

  // Reference: after each accepted sample, once a full window of delayed pairs exists,
  // evaluate the correlation and energy sums directly and saturate to 32-bit fields.
  task automatic model_accept(input logic [31:0] d);
    cplx_t  x, a, b;
    longint ci, cq, p;
    int     n;
    x = d;
    xs.push_back(x);
    n = xs.size();
    if (n >= md + L) begin
      ci = 0; cq = 0; p = 0;
      for (int k = 0; k < L; k++) begin
        a = xs[n-1-k];
        b = xs[n-1-k-md];
        ci += longint'(a.i) * longint'(b.i) + longint'(a.q) * longint'(b.q);
        cq += longint'(a.q) * longint'(b.i) - longint'(a.i) * longint'(b.q);
        p  += longint'(a.i) * longint'(a.i) + longint'(a.q) * longint'(a.q);
      end
      if (ci > 64'sd2147483647) ci = 64'sd2147483647;
      if (ci < -64'sd2147483648) ci = -64'sd2147483648;
      if (cq > 64'sd2147483647) cq = 64'sd2147483647;
      if (cq < -64'sd2147483648) cq = -64'sd2147483648;
      if (p > 64'sd4294967295) p = 64'sd4294967295;
      exp_q.push_back({ci[31:0], cq[31:0], p[31:0]});
      exp_cyc.push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      xs.delete();
      exp_q.delete();
      exp_cyc.delete();
      md = dclamp(int'(cfg_delay));
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_vld", 96'(m_valid), 96'(1));
        chk("hold_dat", m_data, prev_data);
      end
      if (m_valid && !m_ready) chk("stall_srdy", 96'(s_ready), 96'(0));
      if (m_valid && m_ready) begin
        out_cnt++;
        last_out = m_data;
        chk("out_expected", 96'(exp_q.size() != 0), 96'(1));
        if (exp_q.size() != 0) begin
          if (lat_on) chk("latency", 96'(cyc - exp_cyc[0]), 96'(3));
          chk("out_data", m_data, exp_q.pop_front());
          void'(exp_cyc.pop_front());
        end
      end
      if (flush) chk("flush_srdy", 96'(s_ready), 96'(0));
      if (s_valid && s_ready) model_accept(s_data);
      if (flush) begin
        xs.delete();
        exp_q.delete();
        exp_cyc.delete();
        md = dclamp(int'(cfg_delay));
      end
      stall_prev = m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end
    cyc++;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        m_ready = 1'b0;
        stall_cnt--;
      end else begin
        m_ready = ($urandom_range(99) < ready_pct);
      end
    end
  end

  task automatic send(input logic [31:0] d);
    int  t;
    bit  ok;
    t = 0;
    ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      t++;
    end while (!ok && t < 200);
    if (!ok) chk("send_timeout", 96'(ok), 96'(1));
  endtask

  task automatic do_flush(input int d);
    s_valid   = 1'b0;
    cfg_delay = 7'(d);
    flush     = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    s_valid = 1'b0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 96'(exp_q.size()), 96'(0));
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] neg_c;
    int          d;
    neg_c = -32'd160000;

    #12;
    chk("rst_mvalid", 96'(m_valid), 96'(0));
    chk("rst_mdata", m_data, 96'(0));
    chk("rst_srdy", 96'(s_ready), 96'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    chk("post_rst_srdy", 96'(s_ready), 96'(0));

    // Constant tone, D=16: first output from sample 32.
    do_flush(16);
    out_cnt = 0;
    lat_on  = 1;
    for (int i = 0; i < 40; i++) send(32'h0064_0000);
    drain();
    lat_on = 0;
    chk("t1_count", 96'(out_cnt), 96'(9));
    chk("t1_last", last_out, {32'd160000, 32'd0, 32'd160000});

    // Alternating sign: in phase at D=16, anti-phase at D=1.
    do_flush(16);
    for (int i = 0; i < 40; i++) send((i % 2) ? 32'hFF9C_0000 : 32'h0064_0000);
    drain();
    chk("t2_d16_last", last_out, {32'd160000, 32'd0, 32'd160000});
    do_flush(1);
    out_cnt = 0;
    for (int i = 0; i < 40; i++) send((i % 2) ? 32'hFF9C_0000 : 32'h0064_0000);
    drain();
    chk("t2_d1_count", 96'(out_cnt), 96'(24));
    chk("t2_d1_last", last_out, {neg_c, 32'd0, 32'd160000});

    // Full-scale input saturates both C_I and P.
    do_flush(16);
    for (int i = 0; i < 40; i++) send(32'h7FFF_7FFF);
    drain();
    chk("t3_sat", last_out, {32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF});

    // Random data, random delay, random back-pressure plus one long stall.
    ready_pct = 70;
    d = int'($urandom_range(MAXD, 1));
    do_flush(d);
    out_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (i == 60) stall_cnt = 10;
      send($urandom);
    end
    drain();
    chk("t4_count", 96'(out_cnt), 96'(150 - (d + L - 1)));

    // Flush in RUN with outputs in flight, then D=64, D=0 and out-of-range D.
    for (int i = 0; i < 30; i++) send($urandom);
    do_flush(64);
    ready_pct = 100;
    out_cnt = 0;
    for (int i = 0; i < 100; i++) send($urandom);
    drain();
    chk("t5_d64_count", 96'(out_cnt), 96'(21));
    do_flush(0);
    out_cnt = 0;
    for (int i = 0; i < 30; i++) send($urandom);
    drain();
    chk("t5_d0_count", 96'(out_cnt), 96'(14));
    do_flush(100);
    out_cnt = 0;
    ready_pct = 80;
    for (int i = 0; i < 90; i++) send($urandom);
    drain();
    chk("t5_dbig_count", 96'(out_cnt), 96'(11));

    // Asynchronous reset mid-stream, then refill from empty with the held cfg_delay.
    ready_pct = 100;
    do_flush(16);
    for (int i = 0; i < 50; i++) send($urandom);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_mvalid", 96'(m_valid), 96'(0));
    chk("t6_srdy", 96'(s_ready), 96'(0));
    chk("t6_mdata", m_data, 96'(0));
    s_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("t6_flush_srdy", 96'(s_ready), 96'(0));
    out_cnt = 0;
    for (int i = 0; i < 40; i++) send($urandom);
    drain();
    chk("t6_count", 96'(out_cnt), 96'(9));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
